// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and data requesters
// Registered outputs; each granted transaction ends on mem_ack or after TIMEOUT busy cycles.
module mem_port_arbiter #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        addr_sel,
    output logic        err
);
    localparam int             CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    logic [1:0]    state;
    logic          last_d;
    logic [CW-1:0] wait_cnt;
    logic          if_ok;
    logic          d_ok;
    logic          grant_d;
    logic          grant_i;
    logic          abort;
    logic          finish;

    // A requester whose done pulse is showing sits out this arbitration round.
    always_comb begin
        if_ok   = if_req & ~if_done;
        d_ok    = d_req & ~d_done;
        grant_d = d_ok & (~if_ok | ~last_d);
        grant_i = if_ok & ~grant_d;
        abort   = (state != IDLE) & ~mem_ack & (wait_cnt == CNT_LAST);
        finish  = (state != IDLE) & (mem_ack | abort);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            wait_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            addr_sel  <= 1'b0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            if_rdata  <= 32'd0;
            d_rdata   <= 32'd0;
            err       <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (grant_d) begin
                        state     <= BUSY_D;
                        last_d    <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_we ? d_wdata : 32'd0;
                        addr_sel  <= 1'b1;
                    end else if (grant_i) begin
                        state     <= BUSY_I;
                        last_d    <= 1'b0;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= 32'd0;
                        addr_sel  <= 1'b0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (finish) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        if (abort)
                            err <= 1'b1;
                        if (state == BUSY_I) begin
                            if_done  <= 1'b1;
                            if_rdata <= abort ? ERR_DATA : mem_rdata;
                        end else begin
                            d_done  <= 1'b1;
                            d_rdata <= abort ? ERR_DATA : (mem_we ? 32'd0 : mem_rdata);
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed-vector bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        addr_sel;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .addr_sel  (addr_sel),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        bit seen;
        rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        mem_rdata = 0; mem_ack = 0;
        tick();
        check("rst mem_req", 32'(mem_req), 0);
        check("rst addr_sel", 32'(addr_sel), 0);
        check("rst err", 32'(err), 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst dones", 32'({if_done, d_done}), 0);
        tick();
        rst = 1'b0;

        // single fetch, minimum latency, then held request is regranted after the done cycle
        if_req = 1; if_addr = 32'h00400000;
        tick();
        check("f1 mem_req", 32'(mem_req), 1);
        check("f1 mem_addr", mem_addr, 32'h00400000);
        check("f1 addr_sel", 32'(addr_sel), 0);
        check("f1 mem_we", 32'(mem_we), 0);
        check("f1 if_done early", 32'(if_done), 0);
        mem_ack = 1; mem_rdata = 32'h8C080004;
        tick();
        mem_ack = 0;
        check("f1 if_done", 32'(if_done), 1);
        check("f1 if_rdata", if_rdata, 32'h8C080004);
        check("f1 mem_req drop", 32'(mem_req), 0);
        tick();
        check("f1 masked", 32'(mem_req), 0);
        check("f1 if_done once", 32'(if_done), 0);
        tick();
        check("f1 regrant", 32'(mem_req), 1);
        if_req = 0; mem_ack = 1; mem_rdata = 32'h11111111;
        tick();
        mem_ack = 0;
        check("f2 if_rdata", if_rdata, 32'h11111111);
        tick();

        // round robin from reset: data write first, then fetch, then data
        rst = 1'b1;
        if_req = 1; if_addr = 32'h00400000;
        d_req = 1; d_we = 1; d_addr = 32'h10010000; d_wdata = 32'h12345678;
        mem_rdata = 32'h00000055;
        tick();
        rst = 1'b0;
        tick();
        check("rr1 mem_req", 32'(mem_req), 1);
        check("rr1 addr_sel", 32'(addr_sel), 1);
        check("rr1 mem_we", 32'(mem_we), 1);
        check("rr1 mem_addr", mem_addr, 32'h10010000);
        check("rr1 mem_wdata", mem_wdata, 32'h12345678);
        mem_ack = 1;
        tick();
        mem_ack = 0;
        check("rr1 d_done", 32'(d_done), 1);
        check("rr1 if_done", 32'(if_done), 0);
        check("rr1 d_rdata write", d_rdata, 0);
        tick();
        check("rr2 mem_req", 32'(mem_req), 1);
        check("rr2 addr_sel", 32'(addr_sel), 0);
        check("rr2 mem_we", 32'(mem_we), 0);
        check("rr2 mem_addr", mem_addr, 32'h00400000);
        check("rr2 mem_wdata", mem_wdata, 0);
        mem_ack = 1; mem_rdata = 32'h8C080004;
        tick();
        mem_ack = 0;
        check("rr2 if_done", 32'(if_done), 1);
        check("rr2 d_done", 32'(d_done), 0);
        check("rr2 if_rdata", if_rdata, 32'h8C080004);
        tick();
        check("rr3 addr_sel", 32'(addr_sel), 1);
        check("rr3 mem_we", 32'(mem_we), 1);
        if_req = 0; d_req = 0; mem_ack = 1;
        tick();
        mem_ack = 0;
        check("rr3 d_done", 32'(d_done), 1);
        tick();

        // read timeout with no ack
        check("to err before", 32'(err), 0);
        d_req = 1; d_we = 0; d_addr = 32'h00000020;
        busy = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (mem_req) busy++;
            if (d_done) seen = 1;
        end
        check("to done seen", 32'(seen), 1);
        check("to busy cycles", 32'(busy), 16);
        check("to d_rdata", d_rdata, 32'hDEADBEEF);
        check("to err", 32'(err), 1);
        check("to if_done", 32'(if_done), 0);
        d_req = 0; mem_ack = 1;
        tick();
        mem_ack = 0;
        check("to stray ack done", 32'({if_done, d_done}), 0);
        check("to stray ack req", 32'(mem_req), 0);
        if_req = 1; if_addr = 32'h00000100;
        tick();
        if_req = 0; mem_ack = 1; mem_rdata = 32'h0000ABCD;
        tick();
        mem_ack = 0;
        check("to after fetch", if_rdata, 32'h0000ABCD);
        check("to err sticky", 32'(err), 1);
        tick();

        // reset in the middle of a data transaction
        d_req = 1; d_we = 0; d_addr = 32'h00000040;
        tick();
        check("rs busy", 32'(mem_req), 1);
        rst = 1'b1;
        #1;
        check("rs mem_req", 32'(mem_req), 0);
        check("rs addr_sel", 32'(addr_sel), 0);
        check("rs mem_addr", mem_addr, 0);
        check("rs err", 32'(err), 0);
        check("rs d_done", 32'(d_done), 0);
        tick();
        check("rs d_done held", 32'(d_done), 0);
        rst = 1'b0;
        tick();
        check("rs regrant", 32'(mem_req), 1);
        check("rs regrant sel", 32'(addr_sel), 1);
        d_req = 0; mem_ack = 1; mem_rdata = 32'h00C0FFEE;
        tick();
        mem_ack = 0;
        check("rs d_rdata", d_rdata, 32'h00C0FFEE);
        tick();

        // stray ack in idle, then request dropped mid-transaction
        mem_ack = 1;
        tick();
        mem_ack = 0;
        check("sa dones", 32'({if_done, d_done}), 0);
        check("sa mem_req", 32'(mem_req), 0);
        d_req = 1; d_we = 0; d_addr = 32'h00000080;
        tick();
        d_req = 0;
        tick();
        check("dr still busy", 32'(mem_req), 1);
        mem_ack = 1; mem_rdata = 32'h0BADF00D;
        tick();
        mem_ack = 0;
        check("dr d_done", 32'(d_done), 1);
        check("dr d_rdata", d_rdata, 32'h0BADF00D);
        tick();
        check("dr d_done once", 32'(d_done), 0);
        check("dr no regrant", 32'(mem_req), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum cycles a granted transaction waits for mem_ack before abort; legal range 2..256.
REQ-002 Parameter ERR_DATA, default 32'hDEADBEEF: read data returned on an aborted transaction.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 if_req  input  1  instruction-fetch request, level, held until if_done.
REQ-006 if_addr  input  32  fetch address, sampled at grant.
REQ-007 if_rdata  output  32  fetch read data, valid while if_done=1.
REQ-008 if_done  output  1  one-cycle fetch completion pulse.
REQ-009 d_req  input  1  data-access request, level, held until d_done.
REQ-010 d_we  input  1  1=write, 0=read; sampled at grant.
REQ-011 d_addr  input  32  data address, sampled at grant.
REQ-012 d_wdata  input  32  write data, sampled at grant.
REQ-013 d_rdata  output  32  data read result, valid while d_done=1.
REQ-014 d_done  output  1  one-cycle data completion pulse.
REQ-015 mem_req  output  1  memory port request, held high for the whole transaction.
REQ-016 mem_we  output  1  memory write enable, 0 for fetches.
REQ-017 mem_addr  output  32  latched transaction address.
REQ-018 mem_wdata  output  32  latched write data, 0 for fetches and reads.
REQ-019 mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-020 mem_ack  input  1  memory completion, one cycle.
REQ-021 addr_sel  output  1  select for the 32-bit 2:1 address mux: 0=fetch address, 1=data address; stable throughout a transaction.
REQ-022 err  output  1  sticky timeout flag.

Function
REQ-023 FSM states IDLE, BUSY_I, BUSY_D; all outputs driven from registers.
REQ-024 IDLE, only if_req: latch if_addr, addr_sel<=0, mem_we<=0, go BUSY_I; mem_req=1 from the next cycle.
REQ-025 IDLE, only d_req: latch d_addr/d_we/d_wdata, addr_sel<=1, go BUSY_D; mem_req=1 from the next cycle.
REQ-026 IDLE, both requests: round-robin; grant the requester not granted last; last-grant register resets to "fetch" so the first contention goes to data.
REQ-027 BUSY_x with mem_ack=1: capture mem_rdata into x_rdata, drop mem_req, pulse x_done for exactly the following cycle, return to IDLE.
REQ-028 Minimum latency: request seen in cycle N -> mem_req in N+1 -> ack in N+1 -> done in N+2.
REQ-029 In the cycle x_done=1, x_req is masked from arbitration; a requester holding x_req high is granted in the next cycle (new transaction).
REQ-030 Write transactions (d_we=1) return d_rdata=0 on d_done.
REQ-031 Wait counter clears at grant and increments each BUSY cycle with mem_ack=0; on reaching TIMEOUT-1 without ack: abort, drop mem_req, pulse x_done with x_rdata=ERR_DATA, set err, return to IDLE.
REQ-032 mem_ack in IDLE is ignored; mem_ack in the abort cycle is ignored.
REQ-033 Request deassertion during BUSY is ignored; the transaction completes normally.
REQ-034 err stays 1 until reset; arbitration continues normally after a timeout.
REQ-035 if_done and d_done are never high in the same cycle.

Reset
REQ-036 rst=1 immediately forces IDLE; mem_req, mem_we, mem_addr, mem_wdata, addr_sel, if_done, d_done, if_rdata, d_rdata, err, wait counter = 0; last-grant = fetch.
REQ-037 Reset mid-transaction abandons it with no done pulse; first grant occurs the cycle after rst deasserts, given a pending request.

Verification
REQ-038 if_req=1, if_addr=0x00400000, ack 1 cycle after mem_req, mem_rdata=0x8C080004 -> mem_addr=0x00400000, addr_sel=0, if_rdata=0x8C080004, if_done pulse at N+2.
REQ-039 if_req and d_req both high from reset, d_addr=0x10010000, d_we=1, d_wdata=0x12345678 -> data served first (mem_we=1, addr_sel=1, d_rdata=0), then fetch, then data again while both stay asserted.
REQ-040 d_req read, mem_ack never asserted -> after 16 BUSY cycles d_done pulse, d_rdata=0xDEADBEEF, err=1 and remains 1.
REQ-041 rst pulsed while BUSY_D with mem_req=1 -> all outputs 0 the same cycle, no d_done; held d_req regranted after rst release.
REQ-042 Stray mem_ack in IDLE, plus d_req dropped mid-BUSY -> no done pulse from the stray ack; dropped request still completes with one d_done.
